// File: rtl/vixen_iq_scheduler.sv
// Unified issue queue and scheduler for an SMT out-of-order core.
//
// Accepts up to DISP_W renamed micro-ops per cycle. Source readiness is
// tracked through tag wakeup broadcasts. Each port issues the oldest ready
// micro-op, with round-robin preference between threads and per-thread flush.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   disp_*_i            dispatch group; slot k occupies field k of each vector.
//                       disp_src_tag_i slot k = {src2, src1} tags.
//                       disp_src_rdy_i bit 2k = src1, bit 2k+1 = src2.
//   disp_ready_o        a full DISP_W group can be accepted this cycle
//   wake_valid_i/tag_i  tag wakeup broadcast buses
//   port_busy_i         per-port issue back-pressure
//   flush_valid_i       invalidate every entry of flush_thread_i
//   flush_thread_i      thread to flush
//   issue_*_o           registered per-port issue outputs
//   free_count_o        registered count of free entries
module vixen_iq_scheduler #(
    parameter int unsigned IQ_DEPTH    = 16,
    parameter int unsigned DISP_W      = 2,
    parameter int unsigned NUM_PORTS   = 3,
    parameter int unsigned NUM_THREADS = 2,
    parameter int unsigned WAKE_W      = 2,
    parameter int unsigned UOP_W       = 64,
    parameter int unsigned TAG_W       = 7,
    parameter int unsigned ROB_ID_W    = 6,
    localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int unsigned CNT_W = $clog2(IQ_DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DISP_W-1:0]               disp_valid_i,
    input  logic [DISP_W*UOP_W-1:0]         disp_uop_i,
    input  logic [DISP_W*2*TAG_W-1:0]       disp_src_tag_i,
    input  logic [DISP_W*2-1:0]             disp_src_rdy_i,
    input  logic [DISP_W*NUM_PORTS-1:0]     disp_port_mask_i,
    input  logic [DISP_W*TID_W-1:0]         disp_thread_i,
    input  logic [DISP_W*ROB_ID_W-1:0]      disp_rob_id_i,
    output logic                            disp_ready_o,
    input  logic [WAKE_W-1:0]               wake_valid_i,
    input  logic [WAKE_W*TAG_W-1:0]         wake_tag_i,
    input  logic [NUM_PORTS-1:0]            port_busy_i,
    input  logic                            flush_valid_i,
    input  logic [TID_W-1:0]                flush_thread_i,
    output logic [NUM_PORTS-1:0]            issue_valid_o,
    output logic [NUM_PORTS*UOP_W-1:0]      issue_uop_o,
    output logic [NUM_PORTS*ROB_ID_W-1:0]   issue_rob_id_o,
    output logic [NUM_PORTS*TID_W-1:0]      issue_thread_o,
    output logic [CNT_W-1:0]                free_count_o
);

    localparam int unsigned SLOT_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

    function automatic logic wake_hit(input logic [TAG_W-1:0]        tag,
                                      input logic [WAKE_W-1:0]       v,
                                      input logic [WAKE_W*TAG_W-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WAKE_W; w++) begin
            if (v[w] && (t[w*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Per-slot views of the flat dispatch vectors
    logic [UOP_W-1:0]     s_uop    [DISP_W];
    logic [TAG_W-1:0]     s_tag1   [DISP_W];
    logic [TAG_W-1:0]     s_tag2   [DISP_W];
    logic [NUM_PORTS-1:0] s_pmask  [DISP_W];
    logic [TID_W-1:0]     s_thread [DISP_W];
    logic [ROB_ID_W-1:0]  s_rob    [DISP_W];

    for (genvar k = 0; k < DISP_W; k++) begin : g_slot
        assign s_uop[k]    = disp_uop_i[k*UOP_W +: UOP_W];
        assign s_tag1[k]   = disp_src_tag_i[k*2*TAG_W +: TAG_W];
        assign s_tag2[k]   = disp_src_tag_i[k*2*TAG_W+TAG_W +: TAG_W];
        assign s_pmask[k]  = disp_port_mask_i[k*NUM_PORTS +: NUM_PORTS];
        assign s_thread[k] = disp_thread_i[k*TID_W +: TID_W];
        assign s_rob[k]    = disp_rob_id_i[k*ROB_ID_W +: ROB_ID_W];
    end

    // Entry state; age_q[j][i] = 1 means entry j is older than entry i
    logic [IQ_DEPTH-1:0]  valid_q, rdy1_q, rdy2_q;
    logic [IQ_DEPTH-1:0]  age_q    [IQ_DEPTH];
    logic [IQ_DEPTH-1:0]  age_d    [IQ_DEPTH];
    logic [TAG_W-1:0]     tag1_q   [IQ_DEPTH];
    logic [TAG_W-1:0]     tag2_q   [IQ_DEPTH];
    logic [NUM_PORTS-1:0] pmask_q  [IQ_DEPTH];
    logic [TID_W-1:0]     thread_q [IQ_DEPTH];
    logic [ROB_ID_W-1:0]  rob_q    [IQ_DEPTH];
    logic [UOP_W-1:0]     uop_q    [IQ_DEPTH];
    logic [TID_W-1:0]     rr_q, rr_d;
    logic [CNT_W-1:0]     free_count_q, free_count_d;

    logic [NUM_PORTS-1:0] iss_valid_q, iss_valid_d;
    logic [UOP_W-1:0]     iss_uop_q    [NUM_PORTS];
    logic [UOP_W-1:0]     iss_uop_d    [NUM_PORTS];
    logic [ROB_ID_W-1:0]  iss_rob_q    [NUM_PORTS];
    logic [ROB_ID_W-1:0]  iss_rob_d    [NUM_PORTS];
    logic [TID_W-1:0]     iss_thread_q [NUM_PORTS];
    logic [TID_W-1:0]     iss_thread_d [NUM_PORTS];

    logic [IQ_DEPTH-1:0]    ent_rdy, kill, freed, avail, pref, taken, valid_nx;
    logic [IQ_DEPTH-1:0]    grant [NUM_PORTS];
    logic                   older;
    logic [NUM_THREADS-1:0] thr_has;
    int unsigned            n_has;

    logic [IQ_DEPTH-1:0] free_m, seen, wr_en;
    logic [SLOT_W-1:0]   wr_slot [IQ_DEPTH];
    logic                found;

    assign disp_ready_o = (free_count_q >= CNT_W'(DISP_W));
    assign free_count_o = free_count_q;

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            ent_rdy[i] = valid_q[i] & rdy1_q[i] & rdy2_q[i];
            kill[i]    = flush_valid_i & valid_q[i] & (thread_q[i] == flush_thread_i);
        end
    end

    // Select: ports in ascending order, preferred thread first, oldest wins
    always_comb begin
        taken = '0;
        avail = '0;
        pref  = '0;
        older = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            grant[p] = '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                avail[i] = ent_rdy[i] & pmask_q[i][p] & ~port_busy_i[p] & ~taken[i];
                pref[i]  = avail[i] & (thread_q[i] == rr_q);
            end
            if (pref != '0) avail = pref;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (avail[i]) begin
                    older = 1'b0;
                    for (int j = 0; j < IQ_DEPTH; j++) begin
                        if (avail[j] && age_q[j][i]) older = 1'b1;
                    end
                    if (!older) grant[p][i] = 1'b1;
                end
            end
            taken = taken | grant[p];
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            iss_valid_d[p]  = 1'b0;
            iss_uop_d[p]    = '0;
            iss_rob_d[p]    = '0;
            iss_thread_d[p] = '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (grant[p][i]) begin
                    // A grant to the thread being flushed this cycle is dropped
                    iss_valid_d[p]  = ~(flush_valid_i & (thread_q[i] == flush_thread_i));
                    iss_uop_d[p]    = uop_q[i];
                    iss_rob_d[p]    = rob_q[i];
                    iss_thread_d[p] = thread_q[i];
                end
            end
        end

        // Fairness pointer moves only when at least two threads compete
        thr_has = '0;
        n_has   = 0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (ent_rdy[i] && ((pmask_q[i] & ~port_busy_i) != '0)) thr_has[thread_q[i]] = 1'b1;
        end
        for (int t = 0; t < NUM_THREADS; t++) n_has += 32'(thr_has[t]);
        rr_d = rr_q;
        if (n_has >= 2) begin
            rr_d = (rr_q == TID_W'(NUM_THREADS - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    // Allocation: written slots take the lowest free entries in slot order
    always_comb begin
        free_m = ~valid_q;
        seen   = valid_q;
        wr_en  = '0;
        found  = 1'b0;
        age_d  = age_q;
        for (int i = 0; i < IQ_DEPTH; i++) wr_slot[i] = '0;
        for (int k = 0; k < DISP_W; k++) begin
            if (disp_ready_o && disp_valid_i[k] &&
                !(flush_valid_i && (s_thread[k] == flush_thread_i))) begin
                found = 1'b0;
                for (int i = 0; i < IQ_DEPTH; i++) begin
                    if (!found && free_m[i]) begin
                        found      = 1'b1;
                        free_m[i]  = 1'b0;
                        wr_en[i]   = 1'b1;
                        wr_slot[i] = SLOT_W'(k);
                        // New entry is younger than everything present so far
                        for (int j = 0; j < IQ_DEPTH; j++) begin
                            age_d[j][i] = seen[j];
                            age_d[i][j] = 1'b0;
                        end
                        seen[i] = 1'b1;
                    end
                end
            end
        end
        freed        = taken | kill;
        valid_nx     = (valid_q & ~freed) | wr_en;
        free_count_d = '0;
        for (int i = 0; i < IQ_DEPTH; i++) free_count_d += CNT_W'(!valid_nx[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            rdy1_q       <= '0;
            rdy2_q       <= '0;
            age_q        <= '{default: '0};
            rr_q         <= '0;
            free_count_q <= CNT_W'(IQ_DEPTH);
            iss_valid_q  <= '0;
            iss_uop_q    <= '{default: '0};
            iss_rob_q    <= '{default: '0};
            iss_thread_q <= '{default: '0};
        end else begin
            valid_q      <= valid_nx;
            age_q        <= age_d;
            rr_q         <= rr_d;
            free_count_q <= free_count_d;
            iss_valid_q  <= iss_valid_d;
            iss_uop_q    <= iss_uop_d;
            iss_rob_q    <= iss_rob_d;
            iss_thread_q <= iss_thread_d;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (wr_en[i]) begin
                    rdy1_q[i] <= disp_src_rdy_i[2*wr_slot[i]] |
                                 wake_hit(s_tag1[wr_slot[i]], wake_valid_i, wake_tag_i);
                    rdy2_q[i] <= disp_src_rdy_i[2*wr_slot[i]+1] |
                                 wake_hit(s_tag2[wr_slot[i]], wake_valid_i, wake_tag_i);
                end else begin
                    rdy1_q[i] <= rdy1_q[i] | wake_hit(tag1_q[i], wake_valid_i, wake_tag_i);
                    rdy2_q[i] <= rdy2_q[i] | wake_hit(tag2_q[i], wake_valid_i, wake_tag_i);
                end
            end
        end
    end

    // Payload fields are only meaningful while valid, so they need no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (wr_en[i]) begin
                tag1_q[i]   <= s_tag1[wr_slot[i]];
                tag2_q[i]   <= s_tag2[wr_slot[i]];
                pmask_q[i]  <= s_pmask[wr_slot[i]];
                thread_q[i] <= s_thread[wr_slot[i]];
                rob_q[i]    <= s_rob[wr_slot[i]];
                uop_q[i]    <= s_uop[wr_slot[i]];
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign issue_valid_o[p]                      = iss_valid_q[p];
        assign issue_uop_o[p*UOP_W +: UOP_W]         = iss_uop_q[p];
        assign issue_rob_id_o[p*ROB_ID_W +: ROB_ID_W] = iss_rob_q[p];
        assign issue_thread_o[p*TID_W +: TID_W]      = iss_thread_q[p];
    end

endmodule

// File: tb/tb_vixen_iq_scheduler.sv
// Directed testbench for vixen_iq_scheduler with default parameters.
module tb_vixen_iq_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   disp_valid;
    logic [127:0] disp_uop;
    logic [27:0]  disp_src_tag;
    logic [3:0]   disp_src_rdy;
    logic [5:0]   disp_port_mask;
    logic [1:0]   disp_thread;
    logic [11:0]  disp_rob_id;
    logic         disp_ready;
    logic [1:0]   wake_valid;
    logic [13:0]  wake_tag;
    logic [2:0]   port_busy;
    logic         flush_valid;
    logic         flush_thread;
    logic [2:0]   issue_valid;
    logic [191:0] issue_uop;
    logic [17:0]  issue_rob_id;
    logic [2:0]   issue_thread;
    logic [4:0]   free_count;

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;

    always #5 clk = ~clk;

    vixen_iq_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .disp_valid_i     (disp_valid),
        .disp_uop_i       (disp_uop),
        .disp_src_tag_i   (disp_src_tag),
        .disp_src_rdy_i   (disp_src_rdy),
        .disp_port_mask_i (disp_port_mask),
        .disp_thread_i    (disp_thread),
        .disp_rob_id_i    (disp_rob_id),
        .disp_ready_o     (disp_ready),
        .wake_valid_i     (wake_valid),
        .wake_tag_i       (wake_tag),
        .port_busy_i      (port_busy),
        .flush_valid_i    (flush_valid),
        .flush_thread_i   (flush_thread),
        .issue_valid_o    (issue_valid),
        .issue_uop_o      (issue_uop),
        .issue_rob_id_o   (issue_rob_id),
        .issue_thread_o   (issue_thread),
        .free_count_o     (free_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_disp();
        disp_valid     = '0;
        disp_uop       = '0;
        disp_src_tag   = '0;
        disp_src_rdy   = '0;
        disp_port_mask = '0;
        disp_thread    = '0;
        disp_rob_id    = '0;
    endtask

    // rdy = {src2_rdy, src1_rdy}; src2 tag is parked on 0x7f
    task automatic set_slot(input int k, input logic [5:0] rob, input logic [2:0] pm,
                            input logic thr, input logic [1:0] rdy, input logic [6:0] t1);
        disp_valid[k]              = 1'b1;
        disp_uop[k*64 +: 64]       = 64'hC0DE_0000_0000_0000 | 64'(rob);
        disp_src_tag[k*14 +: 14]   = {7'h7f, t1};
        disp_src_rdy[k*2 +: 2]     = rdy;
        disp_port_mask[k*3 +: 3]   = pm;
        disp_thread[k]             = thr;
        disp_rob_id[k*6 +: 6]      = rob;
    endtask

    function automatic logic [5:0] rob_at(input int p);
        return issue_rob_id[p*6 +: 6];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [5:0] exp_rob [8];
        logic       exp_thr [8];
        clear_disp();
        wake_valid   = '0;
        wake_tag     = '0;
        port_busy    = '0;
        flush_valid  = 1'b0;
        flush_thread = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_free_count", 64'(free_count), 64'd16);
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Two ready uops to ports 0 and 1
        set_slot(0, 6'd1, 3'b001, 1'b0, 2'b11, 7'h00);
        set_slot(1, 6'd2, 3'b010, 1'b0, 2'b11, 7'h00);
        tick();
        clear_disp();
        check("basic_not_early", 64'(issue_valid), 64'd0);
        check("basic_fc_written", 64'(free_count), 64'd14);
        tick();
        check("basic_valid", 64'(issue_valid), 64'b011);
        check("basic_rob_p0", 64'(rob_at(0)), 64'd1);
        check("basic_rob_p1", 64'(rob_at(1)), 64'd2);
        check("basic_uop_p0", issue_uop[63:0], 64'hC0DE_0000_0000_0001);
        check("basic_fc_back", 64'(free_count), 64'd16);
        tick();
        check("basic_idle", 64'(issue_valid), 64'd0);

        // Port priority: both can use any port, oldest goes to port 0
        set_slot(0, 6'd7, 3'b111, 1'b0, 2'b11, 7'h00);
        set_slot(1, 6'd8, 3'b111, 1'b0, 2'b11, 7'h00);
        tick();
        clear_disp();
        tick();
        check("order_valid", 64'(issue_valid), 64'b011);
        check("order_rob_p0", 64'(rob_at(0)), 64'd7);
        check("order_rob_p1", 64'(rob_at(1)), 64'd8);
        tick();

        // Wakeup three cycles after dispatch
        set_slot(0, 6'd5, 3'b001, 1'b0, 2'b10, 7'h15);
        tick();
        clear_disp();
        tick();
        check("wake_wait1", 64'(issue_valid), 64'd0);
        tick();
        check("wake_wait2", 64'(issue_valid), 64'd0);
        wake_valid = 2'b01;
        wake_tag   = {7'h00, 7'h15};
        tick();
        wake_valid = '0;
        wake_tag   = '0;
        check("wake_not_early", 64'(issue_valid), 64'd0);
        tick();
        check("wake_valid", 64'(issue_valid), 64'b001);
        check("wake_rob", 64'(rob_at(0)), 64'd5);
        tick();
        check("wake_idle", 64'(issue_valid), 64'd0);

        // Wakeup in the dispatch cycle on bus 1
        set_slot(0, 6'd9, 3'b001, 1'b0, 2'b10, 7'h22);
        wake_valid = 2'b10;
        wake_tag   = {7'h22, 7'h00};
        tick();
        clear_disp();
        wake_valid = '0;
        wake_tag   = '0;
        tick();
        check("wake_disp_valid", 64'(issue_valid), 64'b001);
        check("wake_disp_rob", 64'(rob_at(0)), 64'd9);
        tick();

        // Fill all 16 entries while ports are busy
        port_busy = 3'b111;
        for (int g = 0; g < 8; g++) begin
            set_slot(0, 6'(2*g), 3'b001, 1'b0, 2'b11, 7'h00);
            set_slot(1, 6'(2*g+1), 3'b001, 1'b0, 2'b11, 7'h00);
            tick();
            check("fill_fc", 64'(free_count), 64'(14 - 2*g));
        end
        check("full_disp_ready", 64'(disp_ready), 64'd0);
        set_slot(0, 6'h3f, 3'b001, 1'b0, 2'b11, 7'h00);
        set_slot(1, 6'h3e, 3'b001, 1'b0, 2'b11, 7'h00);
        tick();
        clear_disp();
        check("full_ignored_fc", 64'(free_count), 64'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("busy_no_issue", 64'(issue_valid), 64'd0);
        end
        port_busy = 3'b000;
        for (int r = 0; r < 16; r++) begin
            tick();
            check("drain_valid", 64'(issue_valid), 64'b001);
            check("drain_rob", 64'(rob_at(0)), 64'(r));
            check("drain_fc", 64'(free_count), 64'(r + 1));
            if (r == 0) check("drain_ready_lo", 64'(disp_ready), 64'd0);
            if (r == 1) check("drain_ready_hi", 64'(disp_ready), 64'd1);
        end
        tick();
        check("drain_idle", 64'(issue_valid), 64'd0);
        check("drain_fc_end", 64'(free_count), 64'd16);

        // Round-robin between two threads on port 0
        port_busy = 3'b111;
        for (int g = 0; g < 4; g++) begin
            set_slot(0, 6'(10 + g), 3'b001, 1'b0, 2'b11, 7'h00);
            set_slot(1, 6'(20 + g), 3'b001, 1'b1, 2'b11, 7'h00);
            tick();
        end
        clear_disp();
        port_busy = 3'b000;
        exp_rob = '{6'd10, 6'd20, 6'd11, 6'd21, 6'd12, 6'd22, 6'd13, 6'd23};
        exp_thr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int n = 0; n < 8; n++) begin
            tick();
            check("rr_valid", 64'(issue_valid), 64'b001);
            check("rr_thread", 64'(issue_thread[0]), 64'(exp_thr[n]));
            check("rr_rob", 64'(rob_at(0)), 64'(exp_rob[n]));
        end
        tick();
        check("rr_idle", 64'(issue_valid), 64'd0);

        // Preferred thread (1) empty: thread 0 still issues every cycle
        port_busy = 3'b111;
        set_slot(0, 6'd24, 3'b001, 1'b0, 2'b11, 7'h00);
        set_slot(1, 6'd25, 3'b001, 1'b0, 2'b11, 7'h00);
        tick();
        clear_disp();
        port_busy = 3'b000;
        tick();
        check("solo_rob0", 64'(rob_at(0)), 64'd24);
        check("solo_valid0", 64'(issue_valid), 64'b001);
        tick();
        check("solo_rob1", 64'(rob_at(0)), 64'd25);
        check("solo_valid1", 64'(issue_valid), 64'b001);
        tick();

        // Flush thread 1 with a thread-1 dispatch and a thread-1 grant pending
        port_busy = 3'b111;
        for (int g = 0; g < 3; g++) begin
            set_slot(0, 6'(40 + g), 3'b001, 1'b0, 2'b11, 7'h00);
            set_slot(1, 6'(50 + g), 3'b001, 1'b1, 2'b11, 7'h00);
            tick();
        end
        check("flush_pre_fc", 64'(free_count), 64'd10);
        port_busy    = 3'b000;
        flush_valid  = 1'b1;
        flush_thread = 1'b1;
        set_slot(0, 6'd53, 3'b001, 1'b1, 2'b11, 7'h00);
        set_slot(1, 6'd43, 3'b001, 1'b0, 2'b11, 7'h00);
        tick();
        clear_disp();
        flush_valid  = 1'b0;
        flush_thread = 1'b0;
        check("flush_grant_dropped", 64'(issue_valid), 64'd0);
        check("flush_fc", 64'(free_count), 64'd12);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("flush_t0_valid", 64'(issue_valid), 64'b001);
            check("flush_t0_thread", 64'(issue_thread[0]), 64'd0);
            check("flush_t0_rob", 64'(rob_at(0)), 64'(40 + n));
        end
        tick();
        check("flush_idle", 64'(issue_valid), 64'd0);
        check("flush_fc_end", 64'(free_count), 64'd16);

        // Reset with entries in flight
        port_busy = 3'b111;
        set_slot(0, 6'd60, 3'b001, 1'b0, 2'b11, 7'h00);
        set_slot(1, 6'd61, 3'b001, 1'b0, 2'b11, 7'h00);
        tick();
        clear_disp();
        check("mid_rst_pre_fc", 64'(free_count), 64'd14);
        rst_n = 1'b0;
        #1;
        check("mid_rst_fc", 64'(free_count), 64'd16);
        check("mid_rst_valid", 64'(issue_valid), 64'd0);
        port_busy = 3'b000;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle0", 64'(issue_valid), 64'd0);
        tick();
        check("post_rst_idle1", 64'(issue_valid), 64'd0);
        check("post_rst_fc", 64'(free_count), 64'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/vixen_iq_scheduler.md
Name: vixen_iq_scheduler

Overview:
Parametrised next-generation unified issue queue and scheduler for the Vixen Dio Pro out-of-order core. It accepts up to DISP_W renamed micro-ops per cycle from dispatch and tracks source-operand readiness through tag wakeup broadcasts. Each cycle it selects the oldest ready micro-op per execution port, with SMT round-robin thread fairness and per-thread flush. It sits between rename/ROB allocation and the ALU/AGU/MUL/FPU issue ports.

Parameters:
IQ_DEPTH, 16, number of queue entries (power of two, 4..64)
DISP_W, 2, micro-ops dispatched per cycle
NUM_PORTS, 3, execution issue ports
NUM_THREADS, 2, SMT threads; TID_W = max(1, clog2(NUM_THREADS))
WAKE_W, 2, wakeup broadcast buses per cycle
UOP_W, 64, micro-op payload width
TAG_W, 7, physical register tag width
ROB_ID_W, 6, ROB index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
disp_valid  in  DISP_W  per-slot dispatch valid
disp_uop  in  DISP_W*UOP_W  payloads, slot k at [k*UOP_W +: UOP_W]
disp_src_tag  in  DISP_W*2*TAG_W  src1 then src2 tag per slot
disp_src_rdy  in  DISP_W*2  source already ready at dispatch
disp_port_mask  in  DISP_W*NUM_PORTS  ports able to execute the uop
disp_thread  in  DISP_W*TID_W  thread id
disp_rob_id  in  DISP_W*ROB_ID_W  ROB index
disp_ready  out  1  queue can accept a full DISP_W group this cycle
wake_valid  in  WAKE_W  wakeup bus valid
wake_tag  in  WAKE_W*TAG_W  produced tag
port_busy  in  NUM_PORTS  port cannot accept an issue this cycle
flush_valid  in  1  flush request
flush_thread  in  TID_W  thread to flush
issue_valid  out  NUM_PORTS  registered issue valid
issue_uop  out  NUM_PORTS*UOP_W  issued payload
issue_rob_id  out  NUM_PORTS*ROB_ID_W  issued ROB index
issue_thread  out  NUM_PORTS*TID_W  issued thread id
free_count  out  clog2(IQ_DEPTH)+1  registered free-entry count

Behaviour:
- Reset (async, rst_n low): all entries invalid, age matrix cleared, issue_valid=0, issue_uop/rob_id/thread=0, free_count=IQ_DEPTH, RR pointer=thread 0. Reset mid-operation drops every in-flight entry; nothing issues until rst_n is released.
- disp_ready = (free_count >= DISP_W), computed from registered state only, never from same-cycle issue.
- Dispatch is all-or-nothing. Valid slots are written at the clock edge only when disp_ready=1. Slots with disp_valid=1 while disp_ready=0 are ignored, and the upstream stage must hold them. Valid slots take the lowest-index free entries in slot order, so slot 0 is older than slot 1.
- Entry state: valid, src1_rdy, src2_rdy, tags, port_mask, thread, rob_id, payload. Age is held in an IQ_DEPTH x IQ_DEPTH age matrix. On write, a new entry is younger than every valid entry and than lower-numbered slots in the same group.
- Wakeup: any wake_valid[w] whose tag equals an entry's source tag sets that rdy bit at the edge. The entry is eligible the following cycle. A wakeup in the same cycle as dispatch also matches the incoming sources, so a uop can be ready on entry.
- Select (combinational on registered state, cycle t):
  - Candidates are valid entries with both sources ready, port_mask[p]=1 and port_busy[p]=0.
  - Ports are resolved in order 0..NUM_PORTS-1. An entry granted to a lower port is excluded from higher ports.
  - Each port picks the oldest candidate of the RR-preferred thread. If that thread has none, it picks the oldest candidate of any thread.
  - A granted entry is freed at the t edge, and its fields are registered onto issue_* for cycle t+1. Non-granted ports drive issue_valid[p]=0.
- Minimum dispatch-to-issue_valid latency is 2 cycles. A ready-at-dispatch uop written at edge t is selected in t+1 and appears on issue_* in t+2.
- RR pointer advances (mod NUM_THREADS) only in cycles where ≥2 threads each had at least one candidate. Otherwise it holds.
- Flush: flush_valid=1 invalidates all entries of flush_thread at the edge. Same-cycle dispatch slots of that thread are dropped, while other slots are written. Same-cycle grants to that thread are not registered, so issue_valid[p]=0 next cycle. Already-registered issue outputs are not retracted. Entries of other threads keep their age order.
- free_count(next) = free_count − written + granted-and-freed + flushed. Granted and flushed entries are counted once. The count must never exceed IQ_DEPTH or underflow.
- Full queue (free_count<DISP_W): dispatch stalls. An entry freed by issue in cycle t makes disp_ready rise in t+1.

Test Plan:
- Reset, dispatch 2 uops with all sources ready, port_mask=3'b001 and 3'b010 -> cycle t+2: issue_valid=3'b011, rob_ids match, free_count back to 16.
- Dispatch uop with src1_rdy=0 tag=0x15, wake_tag=0x15 three cycles later -> issue_valid rises exactly 2 cycles after the wakeup cycle, never earlier.
- Fill 16 entries ready for port 0 only, port_busy=0 -> one issue per cycle in dispatch order (rob_id ascending). disp_ready=0 while free_count<2.
- Threads 0 and 1 each have 4 ready port-0 uops -> issue_thread alternates 0,1,0,1...; with only thread 1 ready, thread 1 issues every cycle.
- 6 entries (3 per thread), flush_valid with flush_thread=1 while thread-1 dispatch is pending -> no thread-1 issue from the next cycle on, free_count +3, thread-0 order preserved.
- port_busy=3'b111 for 5 cycles with ready entries -> issue_valid=0 throughout; on release, the oldest entries issue first.
